// File: rtl/control_unit_mc_pkg.sv
// Shared encodings for the copperv multicycle control unit: instruction
// classes, branch conditions, datapath mux selects and FSM state codes.
package control_unit_mc_pkg;

  localparam int INST_TYPE_WIDTH    = 4;
  localparam int FUNCT_WIDTH        = 3;
  localparam int RD_DIN_SEL_WIDTH   = 2;
  localparam int PC_NEXT_SEL_WIDTH  = 3;
  localparam int ALU_DIN1_SEL_WIDTH = 1;
  localparam int ALU_DIN2_SEL_WIDTH = 1;
  localparam int STATE_WIDTH        = 4;

  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JALR    = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_LOAD    = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 4'd7;

  localparam logic [FUNCT_WIDTH-1:0] FUNCT_EQ  = 3'd0;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NE  = 3'd1;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_LT  = 3'd2;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_GE  = 3'd3;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_LTU = 3'd4;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_GEU = 3'd5;

  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_SEL_IMM = 2'd0;
  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_SEL_ALU = 2'd1;
  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_SEL_MEM = 2'd2;
  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_SEL_PC4 = 2'd3;

  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_SEL_STALL  = 3'd0;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_SEL_INCR   = 3'd1;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_SEL_BRANCH = 3'd2;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_SEL_JAL    = 3'd3;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_SEL_JALR   = 3'd4;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_SEL_TRAP   = 3'd5;

  localparam logic [ALU_DIN1_SEL_WIDTH-1:0] ALU_DIN1_SEL_RS1 = 1'b0;
  localparam logic [ALU_DIN1_SEL_WIDTH-1:0] ALU_DIN1_SEL_PC  = 1'b1;
  localparam logic [ALU_DIN2_SEL_WIDTH-1:0] ALU_DIN2_SEL_RS2 = 1'b0;
  localparam logic [ALU_DIN2_SEL_WIDTH-1:0] ALU_DIN2_SEL_IMM = 1'b1;

  typedef enum logic [STATE_WIDTH-1:0] {
    STATE_RESET,
    STATE_FETCH,
    STATE_IDLE,
    STATE_READ,
    STATE_EXEC,
    STATE_BRCOMMIT,
    STATE_MEM_REQ,
    STATE_MEM_RESP,
    STATE_TRAP
  } state_t;

  // Only the six defined conditions may reach the comparator.
  function automatic logic funct_is_branch(input logic [FUNCT_WIDTH-1:0] f);
    return f <= FUNCT_GEU;
  endfunction

endpackage

// File: rtl/control_unit_mc_wait_counter.sv
// cu_wait_counter: loadable saturating down-counter. Shared by the register
// read latency wait and the memory bus timeout; only one is active at a time.
// Ports:
//   clk, rst  clock, synchronous active-high reset (count -> 0)
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one; holds at zero
//   zero      count is zero
module cu_wait_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle control FSM for the copperv core. Sequences
// fetch, register read, execute, branch commit and a valid/ready data bus
// transfer, and traps on memory timeout or an illegal instruction.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   inst_type, funct, inst_valid decoded instruction (sampled in IDLE)
//   rcomp                        comparator result (used in BRCOMMIT)
//   data_req_ready, data_resp_valid  data bus handshake
//   inst_fetch                   fetch request pulse
//   rd_en, rs1_en, rs2_en        register file enables
//   rd_din_sel, pc_next_sel, alu_din1_sel, alu_din2_sel  datapath muxes
//   rcomp_en                     comparator enable
//   data_req_valid, data_req_write  data bus request
//   trap                         timeout / illegal instruction
//
// state     | meaning
// RESET     | post-reset, all outputs idle
// FETCH     | one-cycle instruction fetch request
// IDLE      | wait for inst_valid, capture the decoded instruction
// READ      | register file read, RF_READ_LAT cycles
// EXEC      | drive datapath for the instruction class
// BRCOMMIT  | pick branch target or PC+4 from rcomp
// MEM_REQ   | hold data bus request until ready
// MEM_RESP  | wait for load data / store acknowledge
// TRAP      | trap reported; sticky when TRAP_HALT
module control_unit_mc
  import control_unit_mc_pkg::*;
#(
  parameter int RF_READ_LAT = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_HALT   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INST_TYPE_WIDTH-1:0]    inst_type,
  input  logic [FUNCT_WIDTH-1:0]        funct,
  input  logic                          inst_valid,
  input  logic                          rcomp,
  input  logic                          data_req_ready,
  input  logic                          data_resp_valid,
  output logic                          inst_fetch,
  output logic                          rd_en,
  output logic                          rs1_en,
  output logic                          rs2_en,
  output logic [RD_DIN_SEL_WIDTH-1:0]   rd_din_sel,
  output logic [PC_NEXT_SEL_WIDTH-1:0]  pc_next_sel,
  output logic [ALU_DIN1_SEL_WIDTH-1:0] alu_din1_sel,
  output logic [ALU_DIN2_SEL_WIDTH-1:0] alu_din2_sel,
  output logic                          rcomp_en,
  output logic                          data_req_valid,
  output logic                          data_req_write,
  output logic                          trap
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  // Counter is loaded with N-1 and the wait expires in the cycle it reads
  // zero, so a wait lasts exactly N cycles.
  localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(RF_READ_LAT - 1);
  localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_TIMEOUT - 1);

  state_t                     state, state_next;
  logic [INST_TYPE_WIDTH-1:0] inst_q;
  logic [FUNCT_WIDTH-1:0]     funct_q;
  logic                       cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]           cnt_load_val;
  logic                       is_store;

  cu_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STATE_RESET;
      inst_q  <= '0;
      funct_q <= '0;
    end else begin
      state <= state_next;
      if (state == STATE_IDLE && inst_valid) begin
        inst_q  <= inst_type;
        funct_q <= funct;
      end
    end
  end

  assign is_store = (inst_q == INST_TYPE_STORE);

  always_comb begin
    state_next     = state;
    inst_fetch     = 1'b0;
    rd_en          = 1'b0;
    rs1_en         = 1'b0;
    rs2_en         = 1'b0;
    rd_din_sel     = RD_DIN_SEL_IMM;
    pc_next_sel    = PC_NEXT_SEL_STALL;
    alu_din1_sel   = ALU_DIN1_SEL_RS1;
    alu_din2_sel   = ALU_DIN2_SEL_RS2;
    rcomp_en       = 1'b0;
    data_req_valid = 1'b0;
    data_req_write = 1'b0;
    trap           = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = READ_LOAD;
    cnt_dec        = 1'b0;

    case (state)
      STATE_RESET: state_next = STATE_FETCH;
      STATE_FETCH: begin
        inst_fetch = 1'b1;
        state_next = STATE_IDLE;
      end
      STATE_IDLE: begin
        if (inst_valid) begin
          if (inst_type == INST_TYPE_IMM) begin
            state_next = STATE_EXEC;
          end else begin
            state_next   = STATE_READ;
            cnt_load     = 1'b1;
            cnt_load_val = READ_LOAD;
          end
        end
      end
      STATE_READ: begin
        rs1_en = 1'b1;
        rs2_en = 1'b1;
        if (cnt_zero) state_next = STATE_EXEC;
        else          cnt_dec    = 1'b1;
      end
      STATE_EXEC: begin
        state_next = STATE_FETCH;
        case (inst_q)
          INST_TYPE_IMM: begin
            rd_en       = 1'b1;
            rd_din_sel  = RD_DIN_SEL_IMM;
            pc_next_sel = PC_NEXT_SEL_INCR;
          end
          INST_TYPE_INT_IMM, INST_TYPE_INT_REG: begin
            rd_en        = 1'b1;
            rd_din_sel   = RD_DIN_SEL_ALU;
            alu_din1_sel = ALU_DIN1_SEL_RS1;
            alu_din2_sel = (inst_q == INST_TYPE_INT_IMM) ? ALU_DIN2_SEL_IMM : ALU_DIN2_SEL_RS2;
            pc_next_sel  = PC_NEXT_SEL_INCR;
          end
          INST_TYPE_BRANCH: begin
            // An undefined condition code is treated as an illegal instruction.
            if (funct_is_branch(funct_q)) begin
              alu_din1_sel = ALU_DIN1_SEL_RS1;
              alu_din2_sel = ALU_DIN2_SEL_RS2;
              rcomp_en     = 1'b1;
              state_next   = STATE_BRCOMMIT;
            end else begin
              state_next = STATE_TRAP;
            end
          end
          INST_TYPE_JAL: begin
            rd_en        = 1'b1;
            rd_din_sel   = RD_DIN_SEL_PC4;
            alu_din1_sel = ALU_DIN1_SEL_PC;
            alu_din2_sel = ALU_DIN2_SEL_IMM;
            pc_next_sel  = PC_NEXT_SEL_JAL;
          end
          INST_TYPE_JALR: begin
            rd_en        = 1'b1;
            rd_din_sel   = RD_DIN_SEL_PC4;
            alu_din1_sel = ALU_DIN1_SEL_RS1;
            alu_din2_sel = ALU_DIN2_SEL_IMM;
            pc_next_sel  = PC_NEXT_SEL_JALR;
          end
          INST_TYPE_LOAD, INST_TYPE_STORE: begin
            alu_din1_sel = ALU_DIN1_SEL_RS1;
            alu_din2_sel = ALU_DIN2_SEL_IMM;
            state_next   = STATE_MEM_REQ;
            cnt_load     = 1'b1;
            cnt_load_val = MEM_LOAD;
          end
          default: state_next = STATE_TRAP;
        endcase
      end
      STATE_BRCOMMIT: begin
        pc_next_sel = rcomp ? PC_NEXT_SEL_BRANCH : PC_NEXT_SEL_INCR;
        state_next  = STATE_FETCH;
      end
      STATE_MEM_REQ: begin
        // Address operands stay selected so the request is stable while waiting.
        data_req_valid = 1'b1;
        data_req_write = is_store;
        alu_din1_sel   = ALU_DIN1_SEL_RS1;
        alu_din2_sel   = ALU_DIN2_SEL_IMM;
        if (data_req_ready) begin
          if (data_resp_valid) begin
            pc_next_sel = PC_NEXT_SEL_INCR;
            rd_en       = !is_store;
            rd_din_sel  = is_store ? RD_DIN_SEL_IMM : RD_DIN_SEL_MEM;
            state_next  = STATE_FETCH;
          end else begin
            state_next   = STATE_MEM_RESP;
            cnt_load     = 1'b1;
            cnt_load_val = MEM_LOAD;
          end
        end else if (cnt_zero) begin
          state_next = STATE_TRAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STATE_MEM_RESP: begin
        if (data_resp_valid) begin
          pc_next_sel = PC_NEXT_SEL_INCR;
          rd_en       = !is_store;
          rd_din_sel  = is_store ? RD_DIN_SEL_IMM : RD_DIN_SEL_MEM;
          state_next  = STATE_FETCH;
        end else if (cnt_zero) begin
          state_next = STATE_TRAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STATE_TRAP: begin
        trap        = 1'b1;
        pc_next_sel = PC_NEXT_SEL_TRAP;
        if (!TRAP_HALT) state_next = STATE_FETCH;
      end
      default: state_next = STATE_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit_mc.sv
module tb_control_unit_mc;
  import control_unit_mc_pkg::*;

  localparam int LAT = 3;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inst_type;
  logic [2:0] funct;
  logic       inst_valid, rcomp, data_req_ready, data_resp_valid;
  logic       inst_fetch, rd_en, rs1_en, rs2_en;
  logic [1:0] rd_din_sel;
  logic [2:0] pc_next_sel;
  logic       alu_din1_sel, alu_din2_sel, rcomp_en;
  logic       data_req_valid, data_req_write, trap;

  always #5 clk = ~clk;

  control_unit_mc #(.RF_READ_LAT(LAT), .MEM_TIMEOUT(TMO), .TRAP_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .inst_type(inst_type), .funct(funct),
    .inst_valid(inst_valid), .rcomp(rcomp), .data_req_ready(data_req_ready),
    .data_resp_valid(data_resp_valid), .inst_fetch(inst_fetch), .rd_en(rd_en),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_din_sel(rd_din_sel),
    .pc_next_sel(pc_next_sel), .alu_din1_sel(alu_din1_sel),
    .alu_din2_sel(alu_din2_sel), .rcomp_en(rcomp_en),
    .data_req_valid(data_req_valid), .data_req_write(data_req_write), .trap(trap)
  );

  typedef struct packed {
    logic       inst_fetch, rd_en, rs1_en, rs2_en;
    logic [1:0] rd_din_sel;
    logic [2:0] pc_next_sel;
    logic       din1, din2, rcomp_en, req_valid, req_write, trap;
  } outs_t;

  // One record per clock: inputs to drive and outputs expected in that cycle.
  typedef struct {
    logic        rst;
    logic [3:0]  ty;
    logic [2:0]  fn;
    logic        iv, rc, rdy, rsp;
    outs_t       exp;
    logic        care_alu;  // ALU operand selects are defined this cycle
    logic        care_all;  // every output bit defined (reset)
    logic [63:0] tag;
  } cyc_t;

  cyc_t trace[$];
  int   tests = 0;
  int   fails = 0;

  function automatic cyc_t blank(input logic [3:0] ty, input logic [2:0] fn, input logic [63:0] tag);
    cyc_t c;
    c.rst = 1'b0; c.ty = ty; c.fn = fn;
    c.iv = 1'($urandom); c.rc = 1'($urandom);
    c.rdy = 1'($urandom); c.rsp = 1'($urandom);
    c.exp = '0; c.care_alu = 1'b0; c.care_all = 1'b0; c.tag = tag;
    return c;
  endfunction

  function automatic cyc_t mreq(input logic [3:0] ty, input logic [63:0] tag);
    cyc_t c;
    c = blank(ty, 3'd0, tag);
    c.exp.req_valid = 1'b1;
    c.exp.req_write = (ty == INST_TYPE_STORE);
    c.exp.din1 = ALU_DIN1_SEL_RS1; c.exp.din2 = ALU_DIN2_SEL_IMM;
    c.care_alu = 1'b1;
    c.rdy = 1'b0; c.rsp = 1'b0;
    return c;
  endfunction

  task automatic finish_mem(inout cyc_t c, input logic [3:0] ty);
    c.exp.pc_next_sel = PC_NEXT_SEL_INCR;
    if (ty == INST_TYPE_LOAD) begin
      c.exp.rd_en = 1'b1;
      c.exp.rd_din_sel = RD_DIN_SEL_MEM;
    end
  endtask

  task automatic trap_cycle(input logic [3:0] ty);
    cyc_t c;
    c = blank(ty, 3'd0, "TRAP");
    c.exp.trap = 1'b1;
    c.exp.pc_next_sel = PC_NEXT_SEL_TRAP;
    trace.push_back(c);
  endtask

  task automatic front(input logic [3:0] ty, input logic [2:0] fn, input int vdel);
    cyc_t c;
    c = blank(ty, fn, "FETCH"); c.exp.inst_fetch = 1'b1; trace.push_back(c);
    for (int k = 0; k < vdel; k++) begin
      c = blank(ty, fn, "IDLE"); c.iv = 1'b0; trace.push_back(c);
    end
    c = blank(ty, fn, "ACCEPT"); c.iv = 1'b1; trace.push_back(c);
    if (ty != INST_TYPE_IMM)
      for (int k = 0; k < LAT; k++) begin
        c = blank(ty, fn, "READ");
        c.exp.rs1_en = 1'b1; c.exp.rs2_en = 1'b1;
        trace.push_back(c);
      end
  endtask

  // wreq: cycles with ready low; same: response together with ready;
  // wresp: cycles with response low after the handshake.
  task automatic gen_instr(input logic [3:0] ty, input logic [2:0] fn, input int vdel,
                           input logic rc, input int wreq, input bit same, input int wresp);
    cyc_t c;
    bit   legal;
    legal = (ty <= INST_TYPE_STORE) && (ty != INST_TYPE_BRANCH || fn <= FUNCT_GEU);
    front(ty, fn, vdel);
    c = blank(ty, fn, "EXEC");
    if (!legal) begin
      trace.push_back(c);
      trap_cycle(ty);
      return;
    end
    case (ty)
      INST_TYPE_IMM: begin
        c.exp.rd_en = 1'b1; c.exp.rd_din_sel = RD_DIN_SEL_IMM;
        c.exp.pc_next_sel = PC_NEXT_SEL_INCR;
        trace.push_back(c);
      end
      INST_TYPE_INT_IMM, INST_TYPE_INT_REG: begin
        c.exp.rd_en = 1'b1; c.exp.rd_din_sel = RD_DIN_SEL_ALU;
        c.exp.din1 = ALU_DIN1_SEL_RS1;
        c.exp.din2 = (ty == INST_TYPE_INT_IMM) ? ALU_DIN2_SEL_IMM : ALU_DIN2_SEL_RS2;
        c.exp.pc_next_sel = PC_NEXT_SEL_INCR; c.care_alu = 1'b1;
        trace.push_back(c);
      end
      INST_TYPE_BRANCH: begin
        c.exp.din1 = ALU_DIN1_SEL_RS1; c.exp.din2 = ALU_DIN2_SEL_RS2;
        c.exp.rcomp_en = 1'b1; c.care_alu = 1'b1;
        trace.push_back(c);
        c = blank(ty, fn, "BRCOMMIT");
        c.rc = rc;
        c.exp.pc_next_sel = rc ? PC_NEXT_SEL_BRANCH : PC_NEXT_SEL_INCR;
        trace.push_back(c);
      end
      INST_TYPE_JAL, INST_TYPE_JALR: begin
        c.exp.rd_en = 1'b1; c.exp.rd_din_sel = RD_DIN_SEL_PC4;
        if (ty == INST_TYPE_JAL) begin
          c.exp.pc_next_sel = PC_NEXT_SEL_JAL;
        end else begin
          c.exp.pc_next_sel = PC_NEXT_SEL_JALR;
          c.exp.din1 = ALU_DIN1_SEL_RS1; c.exp.din2 = ALU_DIN2_SEL_IMM;
          c.care_alu = 1'b1;
        end
        trace.push_back(c);
      end
      default: begin  // LOAD / STORE
        c.exp.din1 = ALU_DIN1_SEL_RS1; c.exp.din2 = ALU_DIN2_SEL_IMM; c.care_alu = 1'b1;
        trace.push_back(c);
        for (int k = 0; k < ((wreq < TMO) ? wreq : TMO); k++) trace.push_back(mreq(ty, "MEMREQ"));
        if (wreq >= TMO) begin
          trap_cycle(ty);
          return;
        end
        c = mreq(ty, "HSHAKE"); c.rdy = 1'b1; c.rsp = same;
        if (same) finish_mem(c, ty);
        trace.push_back(c);
        if (same) return;
        for (int k = 0; k < ((wresp < TMO) ? wresp : TMO); k++) begin
          c = blank(ty, fn, "MEMRESP"); c.rsp = 1'b0; trace.push_back(c);
        end
        if (wresp >= TMO) begin
          trap_cycle(ty);
          return;
        end
        c = blank(ty, fn, "RESP"); c.rsp = 1'b1;
        finish_mem(c, ty);
        trace.push_back(c);
      end
    endcase
  endtask

  task automatic reset_in_memreq();
    cyc_t c;
    front(INST_TYPE_LOAD, 3'd0, 1);
    c = blank(INST_TYPE_LOAD, 3'd0, "EXEC");
    c.exp.din1 = ALU_DIN1_SEL_RS1; c.exp.din2 = ALU_DIN2_SEL_IMM; c.care_alu = 1'b1;
    trace.push_back(c);
    trace.push_back(mreq(INST_TYPE_LOAD, "MEMREQ"));
    c = mreq(INST_TYPE_LOAD, "RSTMREQ"); c.rst = 1'b1; trace.push_back(c);
    for (int k = 0; k < 2; k++) begin
      c = blank(INST_TYPE_LOAD, 3'd0, "RSTHOLD"); c.rst = 1'b1; c.care_all = 1'b1;
      trace.push_back(c);
    end
    c = blank(INST_TYPE_LOAD, 3'd0, "RESET"); c.care_all = 1'b1; trace.push_back(c);
  endtask

  function automatic outs_t masked(input outs_t o, input cyc_t c);
    outs_t m;
    m = o;
    if (!c.care_all) begin
      if (!c.care_alu) begin m.din1 = 1'b0; m.din2 = 1'b0; end
      if (!c.exp.rd_en) m.rd_din_sel = '0;
      if (!c.exp.req_valid) m.req_write = 1'b0;
    end
    return m;
  endfunction

  initial begin
    cyc_t  c;
    outs_t got, g, e;
    rst = 1'b1; inst_type = '0; funct = '0; inst_valid = 1'b0;
    rcomp = 1'b0; data_req_ready = 1'b0; data_resp_valid = 1'b0;
    repeat (3) @(posedge clk);

    c = blank(4'd0, 3'd0, "RESET"); c.care_all = 1'b1; trace.push_back(c);
    // Directed corner cases.
    gen_instr(INST_TYPE_INT_REG, 3'd0, 2, 1'b0, 0, 1'b0, 0);
    gen_instr(INST_TYPE_BRANCH, FUNCT_LTU, 0, 1'b1, 0, 1'b0, 0);
    gen_instr(INST_TYPE_BRANCH, FUNCT_LTU, 1, 1'b0, 0, 1'b0, 0);
    gen_instr(INST_TYPE_LOAD, 3'd0, 0, 1'b0, 4, 1'b0, 1);
    gen_instr(INST_TYPE_STORE, 3'd0, 0, 1'b0, 1000, 1'b0, 0);
    gen_instr(INST_TYPE_JALR, 3'd0, 0, 1'b0, 0, 1'b0, 0);
    gen_instr(INST_TYPE_JAL, 3'd0, 0, 1'b0, 0, 1'b0, 0);
    gen_instr(INST_TYPE_IMM, 3'd0, 3, 1'b0, 0, 1'b0, 0);
    gen_instr(INST_TYPE_INT_IMM, 3'd0, 0, 1'b0, 0, 1'b0, 0);
    gen_instr(4'd11, 3'd0, 0, 1'b0, 0, 1'b0, 0);
    gen_instr(INST_TYPE_LOAD, 3'd0, 0, 1'b0, 15, 1'b1, 0);
    gen_instr(INST_TYPE_STORE, 3'd0, 0, 1'b0, 0, 1'b0, 15);
    gen_instr(INST_TYPE_LOAD, 3'd0, 0, 1'b0, 2, 1'b0, 16);
    gen_instr(INST_TYPE_STORE, 3'd0, 0, 1'b0, 1, 1'b0, 0);
    reset_in_memreq();
    gen_instr(INST_TYPE_INT_IMM, 3'd0, 1, 1'b0, 0, 1'b0, 0);
    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      logic [3:0] ty;
      int         wreq, wresp;
      ty = ($urandom_range(0, 15) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      wreq  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 4));
      wresp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 4));
      gen_instr(ty, 3'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'($urandom),
                wreq, ($urandom_range(0, 3) == 0), wresp);
    end

    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      rst = trace[i].rst; inst_type = trace[i].ty; funct = trace[i].fn;
      inst_valid = trace[i].iv; rcomp = trace[i].rc;
      data_req_ready = trace[i].rdy; data_resp_valid = trace[i].rsp;
      #1;
      got.inst_fetch = inst_fetch; got.rd_en = rd_en; got.rs1_en = rs1_en;
      got.rs2_en = rs2_en; got.rd_din_sel = rd_din_sel; got.pc_next_sel = pc_next_sel;
      got.din1 = alu_din1_sel; got.din2 = alu_din2_sel; got.rcomp_en = rcomp_en;
      got.req_valid = data_req_valid; got.req_write = data_req_write; got.trap = trap;
      g = masked(got, trace[i]);
      e = masked(trace[i].exp, trace[i]);
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: outputs got %h want %h", trace[i].tag, i, g, e);
      end
      if (trace[i].tag == "RESET") begin
        tests++;
        if (got !== outs_t'('0)) begin
          fails++;
          $display("FAIL reset state cycle %0d: outputs got %h want all zero", i, got);
        end
      end
      if (trace[i].tag == "TRAP") begin
        tests++;
        if (trap !== 1'b1 || pc_next_sel !== PC_NEXT_SEL_TRAP || data_req_valid !== 1'b0) begin
          fails++;
          $display("FAIL expired wait cycle %0d: trap %b pc_next_sel %0d data_req_valid %b",
                   i, trap, pc_next_sel, data_req_valid);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
